// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response handshake between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches from imem one request at a time, loads IF/ID. Latency: rvalid at edge N -> id_* after N.
// Backpressure: stall holds IF/ID and parks one response in a skid; no new request until it drains. Redirect overrides stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [31:0]   id_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        kill, kill_n;
  ifid_t       skid, skid_n;
  logic        id_load;
  ifid_t       id_load_dat;
  logic        in_flight;
  logic        unused_redirect_lo;

  assign imem.req  = (state == REQ);
  assign imem.addr = pc;

  // A response is still owed by memory after this edge; it must be killed on redirect.
  assign in_flight = ((state == WAIT) && !imem.rvalid) || ((state == REQ) && imem.gnt);

  assign unused_redirect_lo = ^redirect_pc[1:0];

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    fetch_pc_n  = fetch_pc;
    kill_n      = kill;
    skid_n      = skid;
    id_load     = 1'b0;
    id_load_dat = skid;
    if (redirect) begin
      pc_n   = {redirect_pc[31:2], 2'b00};
      skid_n = '0;
      if (in_flight) begin
        kill_n  = 1'b1;
        state_n = WAIT;
      end else begin
        kill_n  = 1'b0;
        state_n = REQ;
      end
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem.gnt) begin
            fetch_pc_n = pc;
            pc_n       = pc + 32'd4;
            state_n    = WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            if (kill) begin
              kill_n  = 1'b0;
              state_n = REQ;
            end else if (!stall || !id_valid) begin
              id_load     = 1'b1;
              id_load_dat = '{instr: imem.rdata, pc: fetch_pc};
              state_n     = REQ;
            end else begin
              skid_n  = '{instr: imem.rdata, pc: fetch_pc};
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            id_load     = 1'b1;
            id_load_dat = skid;
            state_n     = REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      kill     <= 1'b0;
      skid     <= '0;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fetch_pc <= fetch_pc_n;
      kill     <= kill_n;
      skid     <= skid_n;
      if (redirect) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else if (id_load) begin
        id_valid <= 1'b1;
        id_instr <= id_load_dat.instr;
        id_pc    <= id_load_dat.pc;
      end else if (!stall) begin
        // Decode consumed the word; id_pc keeps its last value.
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the program counter, requests instruction words from instruction memory over a request/grant/response handshake, and loads the IF/ID pipeline register whose `id_instr` output drives the decode controller. It honours stall requests from the hazard unit. It handles branch/jump redirects from EX by flushing the IF/ID register and discarding any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `NOP_INSTR`, 32'h0000_0013, value on `id_instr` when IF/ID holds a bubble (`addi x0,x0,0`)

- `clk` in 1: rising-edge clock
- `reset` in 1: reset, synchronous, active-high
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address (word-aligned)
- `imem_gnt` in 1: memory accepted request this cycle
- `imem_rvalid` in 1: response data valid
- `imem_rdata` in 32: instruction word
- `stall` in 1: decode cannot accept; IF/ID must hold
- `redirect` in 1: taken branch/jump from EX
- `redirect_pc` in 32: redirect target
- `id_valid` out 1: IF/ID holds a real instruction
- `id_instr` out 32: IF/ID instruction, feeds controller `instr`
- `id_pc` out 32: PC of `id_instr`

## Operation
- Registers:
  - `pc`: next fetch address.
  - `fetch_pc`: address of the outstanding request.
  - IF/ID register: `id_valid`, `id_instr`, `id_pc`.
  - One-entry skid buffer: `skid_instr`, `skid_pc`.
  - `kill` flag.
  - FSM state.
- FSM states:
  - IDLE: post-reset, no request.
  - REQ: `imem_req`=1.
  - WAIT: request granted, awaiting `imem_rvalid`.
  - HOLD: response parked in skid because IF/ID full and stalled.
- Outputs: `imem_req` = (state==REQ); `imem_addr` = `pc`.
- Transitions:
  - IDLE -> REQ unconditionally.
  - REQ & `imem_gnt` -> WAIT: `fetch_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000).
  - WAIT & `imem_rvalid` & `kill`: data dropped, `kill`<=0 -> REQ.
  - WAIT & `imem_rvalid` & !`kill` & (!`stall` | !`id_valid`): IF/ID <= {1, `imem_rdata`, `fetch_pc`} -> REQ.
  - WAIT & `imem_rvalid` & !`kill` & `stall` & `id_valid`: skid <= {`imem_rdata`, `fetch_pc`} -> HOLD.
  - HOLD & !`stall`: IF/ID <= skid -> REQ.
- IF/ID consumption: when !`stall` and no new word is loaded this cycle, `id_valid`<=0 and `id_instr`<=`NOP_INSTR` (`id_pc` holds). When `stall`, IF/ID holds unchanged.
- Redirect has highest priority after reset and overrides `stall`. Effects:
  - `pc`<=`{redirect_pc[31:2],2'b00}`.
  - IF/ID flushed (`id_valid`=0, `id_instr`=NOP).
  - Skid discarded.
  - Next state depends on whether a request is in flight:
    - A request is in flight if state==WAIT without `imem_rvalid` this cycle, or state==REQ with `imem_gnt` this cycle. Then `kill`<=1 and next state is WAIT.
    - Otherwise next state is REQ.
- Any `imem_rvalid` arriving in the same cycle as `redirect` is dropped.
- A redirect that arrives in REQ without `imem_gnt` simply changes `imem_addr` next cycle. Memory samples the address only on `imem_gnt`.
- At most one outstanding request. `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `fetch_pc`=0, state=IDLE, `kill`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pc`=0, skid=0.
- Reset asserted mid-fetch: all of the above next edge. The outstanding response is ignored because state returns to IDLE.
- First `imem_req` is the 2nd cycle after reset deasserts.
- Latency: `imem_rvalid` at edge N produces `id_valid`/`id_instr` visible after edge N.
- Peak throughput: one instruction per 2 cycles with `imem_gnt` in REQ and `imem_rvalid` the next cycle.
- Redirect at edge N: `id_valid`=0 after N. The target address is presented on `imem_addr` from cycle N+1, with `imem_req` high once nothing is in flight.

## Test plan
- Reset release, memory grants immediately and responds next cycle with mem[a]=a^32'hA5A5_0000 -> `imem_addr` 0,4,8 on successive requests; `id_pc`/`id_instr` match and pulse valid every 2 cycles.
- `stall` held 4 cycles while IF/ID valid and a response arrives -> HOLD entered, `id_instr` unchanged, no new `imem_req`; on release IF/ID = skid word, then REQ resumes.
- `redirect`=1, `redirect_pc`=32'h0000_0102 while in WAIT; rvalid 3 cycles later -> that word dropped, `id_valid`=0, next fetch address 32'h0000_0100.
- `redirect` same cycle as `imem_gnt` in REQ -> old-address response dropped; next request to target.
- Start at `RESET_PC`=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` during WAIT with `stall` and valid IF/ID -> next cycle all reset values; late `imem_rvalid` does not load IF/ID.
